fir_mac_engine: RTL
===================

# fir_mac_engine

Parametrised multiply-accumulate engine for the FIR datapath. One `start` pulse computes one output sample: it walks the coefficient ROM and the sample-history buffer over a run-time tap count, accumulates the products at full precision, then rounds and saturates the result. The output is held behind a valid/ready handshake. The block replaces the fixed 16-bit, fixed-length FIR core and sits between the sample buffer / coefficient ROM and the output sample FIFO.

## Interface
- `NUM_TAPS`, 1021: maximum tap count; sizes the address counter.
- `DATA_W`, 16: signed sample width.
- `COEFF_W`, 16: signed coefficient width.
- `ACC_W`, 42: accumulator width. Must be ≥ DATA_W+COEFF_W+$clog2(NUM_TAPS), so the accumulator never wraps.
- `OUT_W`, 16: signed output width.
- `FRAC_SHIFT`, 15: right shift applied to the accumulator to form the output. Range 0..ACC_W-OUT_W.
- Derived: `ADDR_W` = $clog2(NUM_TAPS); `CNT_W` = $clog2(NUM_TAPS+1).

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request one output. Sampled only while `busy`=0.
- `tap_cnt` in CNT_W: taps to use. Sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `cff_addr` out ADDR_W: coefficient ROM address, registered.
- `cff_data` in COEFF_W: ROM read data. Valid 1 cycle after `cff_addr`.
- `smpl_addr` out ADDR_W: sample-history index (0 = newest), registered. Always equal to `cff_addr`.
- `smpl_data` in DATA_W: history read data. Valid 1 cycle after `smpl_addr`.
- `out_vld` out 1: `smpl_out` valid.
- `out_rdy` in 1: consumer accepts.
- `smpl_out` out OUT_W: rounded, saturated result.
- `sat` out 1: the held result was clipped. Qualified by `out_vld`.

## Operation
- State machine has four states: IDLE, RUN, DRAIN, OUT.
  - IDLE, `start`=1 → RUN. On that edge: latch effective length L, clear the address and the accumulator.
  - RUN issues addresses 0..L-1, one per cycle → DRAIN after address L-1 is issued.
  - DRAIN: 3 cycles while the pipeline empties → OUT. On the final DRAIN edge, load `smpl_out`/`sat` and set `out_vld`.
  - OUT holds until `out_vld && out_rdy`. Then → IDLE and clear `out_vld` on that edge.
- Effective length L: `tap_cnt`=0 or `tap_cnt`>NUM_TAPS → L=NUM_TAPS; otherwise L=`tap_cnt`.
- Datapath pipeline (valid bit carried with each stage):
  - Address stage.
  - Memory stage: read data arrives.
  - Product register: signed DATA_W×COEFF_W full-width product.
  - Accumulate: `accum += sign-extended product`.
- Output formation:
  - r = accum + (FRAC_SHIFT>0 ? 2^(FRAC_SHIFT-1) : 0), i.e. round half up toward +inf.
  - q = r >>> FRAC_SHIFT (arithmetic shift).
  - If q > 2^(OUT_W-1)-1 → output max, `sat`=1. If q < -2^(OUT_W-1) → output min, `sat`=1. Otherwise output q, `sat`=0.
- `start` is ignored whenever `busy`=1, including while in OUT.
- Reset during any state: immediately → IDLE, in-flight result discarded. All outputs return to reset values.
- Reset values: `busy`=0, `out_vld`=0, `smpl_out`=0, `sat`=0, `cff_addr`=`smpl_addr`=0, accumulator=0.
- `cff_addr`/`smpl_addr` hold their last value outside RUN.
- `smpl_out`/`sat` are stable throughout OUT.

## Timing
- Let cycle 0 be the cycle in which `start` is sampled high in IDLE.
- Tap i is addressed in cycle i+1; its data arrives in cycle i+2; its product is registered in cycle i+3; it is included in the accumulator from cycle i+4.
- First `out_vld` cycle = L+4. For L=4, `out_vld` first rises in cycle 8.
- Minimum start-to-start period = L+5 cycles, with `out_rdy` held high.
- Accepting the output (`out_vld && out_rdy`) → `busy`=0 in the next cycle. A `start` in that next cycle is accepted.
- No combinational path from any input to any output.

## Test plan
- Reset: assert `rst_n`=0 mid-RUN with NUM_TAPS=4 → all outputs return to reset values immediately. A following `start` produces a correct result.
- Basic (NUM_TAPS=4, FRAC_SHIFT=15, `tap_cnt`=4): all coeffs 0x4000, all samples 0x1000 → `smpl_out`=0x2000, `sat`=0, `out_vld` first high in cycle 8. Addresses 0,1,2,3 appear in cycles 1–4.
- Saturation: coeffs 0x7FFF with samples 0x7FFF → `smpl_out`=0x7FFF, `sat`=1. Coeffs 0x7FFF with samples 0x8000 → `smpl_out`=0x8000, `sat`=1.
- Rounding, `tap_cnt`=1, coeff 0x0001:
  - sample 0x4000 → `smpl_out`=0x0001.
  - sample 0x3FFF → 0x0000.
  - sample 0xC000 → 0x0000.
  - `out_vld` in cycle 5.
- Backpressure: hold `out_rdy`=0 for 10 cycles in OUT and pulse `start` → `out_vld`, `smpl_out`, `busy` stay stable and `start` is ignored. After `out_rdy`=1: `busy`=0 next cycle, and a new `start` there is accepted.
- Length boundaries (NUM_TAPS=4): `tap_cnt`=0 and `tap_cnt`=7 each → L=4, addresses 0..3, `out_vld` in cycle 8. `tap_cnt`=2 → only addresses 0,1 issued, `out_vld` in cycle 6.

Source files
------------

// File: rtl/fir_mac_engine_if.sv
// Handshake and memory-port bundle between the FIR MAC engine and its environment.
// master = engine side, slave = requester / memories / output consumer side.
interface fir_mac_engine_if #(
    parameter int NUM_TAPS = 1021,
    parameter int DATA_W   = 16,
    parameter int COEFF_W  = 16,
    parameter int OUT_W    = 16
);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int CNT_W  = $clog2(NUM_TAPS + 1);

    logic                 start;
    logic [CNT_W-1:0]     tap_cnt;
    logic                 busy;
    logic [ADDR_W-1:0]    cff_addr;
    logic [COEFF_W-1:0]   cff_data;
    logic [ADDR_W-1:0]    smpl_addr;
    logic [DATA_W-1:0]    smpl_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic [OUT_W-1:0]     smpl_out;
    logic                 sat;

    modport master (
        input  start, tap_cnt, cff_data, smpl_data, out_rdy,
        output busy, cff_addr, smpl_addr, out_vld, smpl_out, sat
    );

    modport slave (
        output start, tap_cnt, cff_data, smpl_data, out_rdy,
        input  busy, cff_addr, smpl_addr, out_vld, smpl_out, sat
    );
endinterface

// File: rtl/fir_mac_engine.sv
// One output sample per start: sums L coeff*sample products, rounds half-up and saturates.
// Latency L+4 cycles to out_vld; result held in OUT until out_rdy, start ignored while busy.
module fir_mac_engine #(
    parameter int NUM_TAPS   = 1021,
    parameter int DATA_W     = 16,
    parameter int COEFF_W    = 16,
    parameter int ACC_W      = 42,
    parameter int OUT_W      = 16,
    parameter int FRAC_SHIFT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    fir_mac_engine_if.master   bus
);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int CNT_W  = $clog2(NUM_TAPS + 1);
    localparam int PROD_W = DATA_W + COEFF_W;

    localparam logic        [ACC_W:0] ONE  = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] RND  = (ONE << FRAC_SHIFT) >> 1;
    localparam logic signed [ACC_W:0] OMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] OMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          len_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [1:0]                dcnt_q;
    logic                      m_vld_q, p_vld_q;
    logic signed [PROD_W-1:0]  prod_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [OUT_W-1:0]          out_q;
    logic                      sat_q, vld_q;

    logic                      last_addr, drain_done, accept;
    logic [CNT_W-1:0]          eff_len;
    logic signed [PROD_W-1:0]  prod_d;
    logic signed [ACC_W-1:0]   acc_fin;
    logic signed [ACC_W:0]     rnd, q;
    logic [OUT_W-1:0]          out_d;
    logic                      sat_d;

    assign last_addr  = (CNT_W'(addr_q) == len_q - CNT_W'(1));
    assign drain_done = (dcnt_q == 2'd2);
    assign accept     = vld_q && bus.out_rdy;
    assign eff_len    = (bus.tap_cnt == '0 || bus.tap_cnt > CNT_W'(NUM_TAPS))
                        ? CNT_W'(NUM_TAPS) : bus.tap_cnt;

    // Final product is folded in combinationally so the last DRAIN edge sees the complete sum.
    assign prod_d  = $signed(bus.smpl_data) * $signed(bus.cff_data);
    assign acc_fin = p_vld_q ? acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q} : acc_q;
    assign rnd     = {acc_fin[ACC_W-1], acc_fin} + RND;
    assign q       = rnd >>> FRAC_SHIFT;

    always_comb begin
        out_d = q[OUT_W-1:0];
        sat_d = 1'b0;
        if (q > OMAX) begin
            out_d = OMAX[OUT_W-1:0];
            sat_d = 1'b1;
        end else if (q < OMIN) begin
            out_d = OMIN[OUT_W-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_addr) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = OUT;
            OUT:     if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            addr_q  <= '0;
            dcnt_q  <= '0;
            m_vld_q <= 1'b0;
            p_vld_q <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            m_vld_q <= (state_q == RUN);
            p_vld_q <= m_vld_q;
            prod_q  <= prod_d;
            dcnt_q  <= (state_q == DRAIN) ? dcnt_q + 2'd1 : 2'd0;
            if (state_q == IDLE && bus.start) begin
                len_q  <= eff_len;
                addr_q <= '0;
                acc_q  <= '0;
            end else begin
                acc_q <= acc_fin;
                if (state_q == RUN && !last_addr) addr_q <= addr_q + ADDR_W'(1);
            end
            if (state_q == DRAIN && drain_done) begin
                out_q <= out_d;
                sat_q <= sat_d;
                vld_q <= 1'b1;
            end else if (state_q == OUT && accept) begin
                vld_q <= 1'b0;
            end
        end
    end

    assign bus.cff_addr  = addr_q;
    assign bus.smpl_addr = addr_q;
    assign bus.out_vld   = vld_q;
    assign bus.smpl_out  = out_q;
    assign bus.sat       = sat_q;
endmodule
